fetch_stage: RTL

Instruction fetch stage plus IF/ID pipeline register for the 4-stage CPU.
- Generates the PC and drives a synchronous (1-cycle read latency) instruction memory.
- Absorbs hazard-unit stalls without losing an in-flight word.
- Redirects on a taken branch, and presents the instruction, PC, valid flag and opcode field to the opcode decoder in the decode stage.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/fetch_skid_buf.sv | 38 +++
 rtl/fetch_stage.sv | 97 +++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants: datapath widths, opcode field position, opcode classes.
package cpu_pkg;
    localparam int PC_WIDTH    = 8;
    localparam int INSTR_WIDTH = 16;
    localparam int OPC_W       = 4;
    localparam int OPC_MSB     = INSTR_WIDTH - 1;

    // 2-bit opcode classes, shared with the opcode decoder
    typedef enum logic [1:0] {
        LDA = 2'b00,
        STA = 2'b01,
        IMM = 2'b10,
        BAF = 2'b11
    } opc_class_e;

    // Bubble decodes as opcode 0000 (a load), so decode must qualify with o_valid
    localparam logic [INSTR_WIDTH-1:0] BUBBLE_INSTR = '0;
endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid buffer that parks the in-flight fetch word while the pipe is stalled.
module fetch_skid_buf
    import cpu_pkg::*;
#(
    parameter int PC_WIDTH    = cpu_pkg::PC_WIDTH,
    parameter int INSTR_WIDTH = cpu_pkg::INSTR_WIDTH
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_clear,
    input  logic                   i_capture,
    input  logic                   i_consume,
    input  logic [INSTR_WIDTH-1:0] i_instr,
    input  logic [PC_WIDTH-1:0]    i_pc,
    output logic                   o_valid,
    output logic [INSTR_WIDTH-1:0] o_instr,
    output logic [PC_WIDTH-1:0]    o_pc
);
    logic                   valid_q;
    logic [INSTR_WIDTH-1:0] instr_q;
    logic [PC_WIDTH-1:0]    pc_q;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            valid_q <= 1'b0;
        end else if (i_capture) begin
            valid_q <= 1'b1;
            instr_q <= i_instr;
            pc_q    <= i_pc;
        end else if (i_consume) begin
            valid_q <= 1'b0;
        end
    end

    assign o_valid = valid_q;
    assign o_instr = instr_q;
    assign o_pc    = pc_q;
endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC generation, sync imem read, stall skid buffer, IF/ID register.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int                  PC_WIDTH    = cpu_pkg::PC_WIDTH,
    parameter int                  INSTR_WIDTH = cpu_pkg::INSTR_WIDTH,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_stall,
    input  logic                   i_flush,
    input  logic [PC_WIDTH-1:0]    i_branch_target,
    output logic                   o_imem_en,
    output logic [PC_WIDTH-1:0]    o_imem_addr,
    input  logic [INSTR_WIDTH-1:0] i_imem_rdata,
    output logic [INSTR_WIDTH-1:0] o_instr,
    output logic [PC_WIDTH-1:0]    o_pc,
    output logic                   o_valid,
    output logic [OPC_W-1:0]       o_opcode
);
    logic [PC_WIDTH-1:0]    pc_q;
    logic                   infl_valid_q;
    logic [PC_WIDTH-1:0]    infl_pc_q;
    logic [INSTR_WIDTH-1:0] ifid_instr_q;
    logic [PC_WIDTH-1:0]    ifid_pc_q;
    logic                   ifid_valid_q;

    logic                   hold_valid;
    logic [INSTR_WIDTH-1:0] hold_instr;
    logic [PC_WIDTH-1:0]    hold_pc;
    logic                   advance;
    logic                   hold_capture;
    logic                   hold_consume;

    assign advance      = !i_reset && !i_flush && !i_stall;
    // Park the word returning during a stall; the memory will not re-present it
    assign hold_capture = !i_reset && !i_flush && i_stall && infl_valid_q && !hold_valid;
    assign hold_consume = advance && hold_valid;

    fetch_skid_buf #(
        .PC_WIDTH   (PC_WIDTH),
        .INSTR_WIDTH(INSTR_WIDTH)
    ) u_skid (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_clear  (i_flush),
        .i_capture(hold_capture),
        .i_consume(hold_consume),
        .i_instr  (i_imem_rdata),
        .i_pc     (infl_pc_q),
        .o_valid  (hold_valid),
        .o_instr  (hold_instr),
        .o_pc     (hold_pc)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            pc_q         <= RESET_PC;
            infl_valid_q <= 1'b0;
            ifid_valid_q <= 1'b0;
            ifid_instr_q <= '0;
            ifid_pc_q    <= '0;
        end else if (i_flush) begin
            pc_q         <= i_branch_target;
            infl_valid_q <= 1'b0;
            ifid_valid_q <= 1'b0;
            ifid_instr_q <= BUBBLE_INSTR[INSTR_WIDTH-1:0];
        end else if (i_stall) begin
            if (hold_capture)
                infl_valid_q <= 1'b0;
        end else begin
            if (hold_valid) begin
                ifid_valid_q <= 1'b1;
                ifid_instr_q <= hold_instr;
                ifid_pc_q    <= hold_pc;
            end else if (infl_valid_q) begin
                ifid_valid_q <= 1'b1;
                ifid_instr_q <= i_imem_rdata;
                ifid_pc_q    <= infl_pc_q;
            end else begin
                ifid_valid_q <= 1'b0;
                ifid_instr_q <= BUBBLE_INSTR[INSTR_WIDTH-1:0];
            end
            infl_valid_q <= 1'b1;
            infl_pc_q    <= pc_q;
            pc_q         <= pc_q + 1'b1;
        end
    end

    assign o_imem_en   = advance;
    assign o_imem_addr = pc_q;
    assign o_instr     = ifid_instr_q;
    assign o_pc        = ifid_pc_q;
    assign o_valid     = ifid_valid_q;
    assign o_opcode    = ifid_instr_q[INSTR_WIDTH-1 -: OPC_W];
endmodule
